// File: rtl/predecode_seq.sv
// predecode_seq: registered burst address sequencer driving one-hot predecode lines,
// with the leading groups qualified by the access-active flop.
module predecode_seq #(
  parameter int ADDR_W       = 6,
  parameter int GROUP_W      = 2,
  parameter int GATED_GROUPS = 1,
  parameter int BURST_W      = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [0:ADDR_W-1]                      req_addr,
  input  logic                                   req_wr,
  input  logic [BURST_W-1:0]                     req_burst,
  output logic                                   out_valid,
  output logic                                   out_wr,
  output logic                                   out_last,
  output logic [0:ADDR_W-1]                      out_addr,
  output logic [(ADDR_W/GROUP_W)*2**GROUP_W-1:0] predec
);
  localparam int NG = ADDR_W / GROUP_W;
  localparam int NL = 2 ** GROUP_W;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t              r_state, w_state;
  logic [0:ADDR_W-1]   r_addr, w_addr;
  logic [BURST_W-1:0]  r_rem, w_rem;
  logic                r_wr, w_wr, r_last, w_last, r_seen, w_acc, w_step;
  assign out_valid = r_state == ACTIVE;
  assign req_ready = r_state == IDLE || r_last;
  assign w_acc     = req_valid && req_ready;
  assign w_step    = out_valid && !r_last;
  assign out_addr  = r_addr;
  assign out_wr    = r_wr;
  assign out_last  = r_last;
  always_comb begin
    w_state = w_acc ? ACTIVE : (out_valid && r_last) ? IDLE : r_state;
    w_addr  = w_acc ? req_addr : w_step ? r_addr + ADDR_W'(1) : r_addr;
    w_wr    = w_acc ? req_wr : r_wr;
    w_rem   = w_acc ? ((|req_burst) ? req_burst - BURST_W'(1) : '0) : w_step ? r_rem - BURST_W'(1) : r_rem;
    w_last  = w_acc ? req_burst <= BURST_W'(1) : w_step && r_rem == BURST_W'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_wr    <= 1'b0;
      r_last  <= 1'b0;
      r_seen  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_rem   <= w_rem;
      r_wr    <= w_wr;
      r_last  <= w_last;
      r_seen  <= r_seen || w_acc;
    end
  end
  // ungated groups keep decoding the held address once any access has been seen
  for (genvar g = 0; g < NG; g++) begin : grp
    assign predec[g*NL +: NL] = NL'(g < GATED_GROUPS ? out_valid : r_seen) << r_addr[g*GROUP_W +: GROUP_W];
  end
endmodule

// File: tb/tb_predecode_seq.sv
// tb_predecode_seq: drives a default and an 8/4/2 instance in lockstep against a beat-queue reference model.
module tb_predecode_seq;
  logic        clk = 0, reset = 1, req_valid = 0, req_wr = 0;
  logic [2:0]  req_burst = 0;
  logic [7:0]  req_a8 = 0;
  logic [5:0]  req_a6;
  logic        rdy0, val0, wr0, last0, rdy1, val1, wr1, last1;
  logic [5:0]  addr0;
  logic [7:0]  addr1;
  logic [11:0] pd0;
  logic [31:0] pd1;
  int          checks = 0, errors = 0;
  typedef struct {logic [5:0] a6; logic [7:0] a8; logic wr; logic last;} beat_t;
  beat_t       q[$];
  logic [5:0]  h6 = 0;
  logic [7:0]  h8 = 0;
  logic        hwr = 0, seen = 0;
  assign req_a6 = req_a8[5:0];
  always #5 clk = ~clk;
  predecode_seq u0 (.clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0), .req_addr(req_a6),
    .req_wr(req_wr), .req_burst(req_burst), .out_valid(val0), .out_wr(wr0), .out_last(last0), .out_addr(addr0), .predec(pd0));
  predecode_seq #(.ADDR_W(8), .GROUP_W(4), .GATED_GROUPS(2), .BURST_W(3)) u1 (.clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(rdy1), .req_addr(req_a8), .req_wr(req_wr), .req_burst(req_burst),
    .out_valid(val1), .out_wr(wr1), .out_last(last1), .out_addr(addr1), .predec(pd1));
  function automatic logic [31:0] pd(int aw, int gw, int gg, int a, logic v, logic s);
    logic [31:0] r = 0;
    for (int g = 0; g < aw / gw; g++) r[g * (1 << gw) + ((a >> (aw - (g + 1) * gw)) & ((1 << gw) - 1))] = g < gg ? v : s;
    return r;
  endfunction
  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask
  task automatic check_all();
    logic v = q.size() > 0;
    chk("valid0", val0, v);
    chk("valid1", val1, v);
    chk("ready0", rdy0, q.size() <= 1);
    chk("ready1", rdy1, q.size() <= 1);
    chk("last0", last0, v ? q[0].last : 1'b0);
    chk("last1", last1, v ? q[0].last : 1'b0);
    chk("wr0", wr0, hwr);
    chk("wr1", wr1, hwr);
    chk("addr0", addr0, h6);
    chk("addr1", addr1, h8);
    chk("predec0", pd0, pd(6, 2, 1, h6, v, seen));
    chk("predec1", pd1, pd(8, 4, 2, h8, v, seen));
  endtask
  task automatic cyc();
    logic acc;
    int n;
    @(posedge clk);
    acc = req_valid && q.size() <= 1;
    if (q.size() > 0) void'(q.pop_front());
    if (acc) begin
      n = req_burst == 0 ? 1 : int'(req_burst);
      for (int i = 0; i < n; i++)
        q.push_back('{a6: 6'(int'(req_a6) + i), a8: 8'(int'(req_a8) + i), wr: req_wr, last: i == n - 1});
      seen = 1;
    end
    if (q.size() > 0) begin
      h6 = q[0].a6;
      h8 = q[0].a8;
      hwr = q[0].wr;
    end
    #1;
    check_all();
  endtask
  task automatic req(logic [7:0] a, logic [2:0] b, logic w);
    req_valid = 1;
    req_a8 = a;
    req_burst = b;
    req_wr = w;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 0;
    cyc();
    check_all();
    req(8'h2D, 3'd1, 0);
    cyc();
    req_valid = 0;
    chk("single_pd", pd0, 32'h284);
    chk("single_last", last0, 1);
    cyc();
    chk("single_idle_pd", pd0, 32'h280);
    chk("single_idle_rdy", rdy0, 1);
    req(8'h3E, 3'd4, 0);
    cyc();
    req_valid = 0;
    repeat (4) cyc();
    chk("wrap_addr", addr0, 6'h01);
    req(8'h05, 3'd2, 0);
    cyc();
    cyc();
    chk("b2b_a_addr", addr0, 6'h06);
    req(8'h20, 3'd1, 1);
    cyc();
    chk("b2b_b_addr", addr0, 6'h20);
    chk("b2b_b_wr", wr0, 1);
    req(8'h11, 3'd0, 0);
    cyc();
    req_valid = 0;
    chk("burst0_last", last0, 1);
    cyc();
    chk("burst0_done", val0, 0);
    req(8'hA7, 3'd1, 0);
    cyc();
    req_valid = 0;
    chk("sweep_pd", pd1, 32'h0080_0400);
    cyc();
    chk("sweep_idle_pd", pd1, 32'h0);
    req(8'h10, 3'd5, 0);
    cyc();
    req_valid = 0;
    cyc();
    #2 reset = 1;
    q.delete();
    h6 = 0;
    h8 = 0;
    hwr = 0;
    seen = 0;
    #1;
    check_all();
    chk("rst_pd", pd0, 32'h0);
    @(posedge clk);
    #1 reset = 0;
    check_all();
    repeat (6) cyc();
    for (int k = 0; k < 400; k++) begin
      req_valid = $urandom_range(0, 9) < 6;
      req_a8 = 8'($urandom);
      req_burst = 3'($urandom_range(0, 7));
      req_wr = 1'($urandom);
      cyc();
    end
    req_valid = 0;
    repeat (10) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
